// File: rtl/run_mon_pkg.sv
// Shared types and channel indices for the CPU run-control monitor.
// Imported by cpu_run_monitor and event_counter.
package run_mon_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      STEP = 2'd2
   } run_state_t;

   localparam int CH_DATA    = 0;
   localparam int CH_EV_BASE = 1;

endpackage

// File: rtl/event_counter.sv
// Single event counter: clear dominates, counts inc while en; wraps, or saturates under RUN_MON_SAT_EN.
// Latency: count visible the cycle after the event. No backpressure.
module event_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && inc) begin
`ifdef RUN_MON_SAT_EN
         if (cnt != {W{1'b1}}) begin
            cnt <= cnt + 1'b1;
         end
`else
         cnt <= cnt + 1'b1;
`endif
      end
   end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run/halt/step control of the core clock-enable, per-event counters and a registered LED mux.
// Latency: state and led_data update one cycle after inputs. No backpressure. Counter mode set by RUN_MON_SAT_EN.
module cpu_run_monitor
   import run_mon_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 3,
   parameter int SEL_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              step,
   input  logic              halt_req,
   input  logic              clr,
   input  logic [NUM_CH-1:0] ev,
   input  logic [DATA_W-1:0] cpu_data,
   input  logic [SEL_W-1:0]  select,
   output logic              cpu_en,
   output logic              halted,
   output logic [DATA_W-1:0] led_data
);

   run_state_t        state_q;
   run_state_t        state_d;
   logic              go_q;
   logic              step_q;
   logic              go_rise;
   logic              step_rise;
   logic [DATA_W-1:0] cnt [NUM_CH];
   logic [DATA_W-1:0] led_d;

   // Edge registers clear to 0, so a level already high after reset reads as a rising edge.
   assign go_rise   = go & ~go_q;
   assign step_rise = step & ~step_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         go_q     <= 1'b0;
         step_q   <= 1'b0;
         led_data <= '0;
      end else begin
         state_q  <= state_d;
         go_q     <= go;
         step_q   <= step;
         led_data <= led_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (halt_req) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (go_rise) begin
               state_d = RUN;
            end else if (step_rise) begin
               state_d = STEP;
            end
         end
         STEP:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   assign cpu_en = (state_q == RUN) || (state_q == STEP);
   assign halted = (state_q == HALT);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
      event_counter #(
         .W(DATA_W)
      ) u_cnt (
         .clk (clk),
         .rst (rst),
         .en  (cpu_en),
         .inc (ev[i]),
         .clr (clr),
         .cnt (cnt[i])
      );
   end

   // Any select beyond the last counter falls through to zero.
   always_comb begin
      led_d = '0;
      if (select == SEL_W'(CH_DATA)) begin
         led_d = cpu_data;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (select == SEL_W'(i + CH_EV_BASE)) begin
            led_d = cnt[i];
         end
      end
   end

endmodule
